// File: rtl/tea_pkg.sv
// Shared types and widths for the TEA core scheduler.
package tea_pkg;

    localparam int TEA_BLOCK_W = 64;
    localparam int TEA_KEY_W   = 128;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RETURN = 2'd3
    } sched_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tea_rr_pick.sv
// Rotate-priority picker: first valid requester at or above ptr_i, wrapping modulo NUM_REQ.
module tea_rr_pick
    import tea_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    logic [IDX_W:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_i} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!any_o && valid_i[cand[IDX_W-1:0]]) begin
                any_o                     = 1'b1;
                grant_o[cand[IDX_W-1:0]]  = 1'b1;
                idx_o                     = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/tea_scheduler.sv
// Round-robin sharing of one TEA core among NUM_REQ requesters, one transaction in flight.
// Optional core watchdog and stale-result drain enabled by defining TEA_SCHED_TIMEOUT_EN.
module tea_scheduler
    import tea_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NUM_REQ-1:0]             i_req_valid,
    output logic [NUM_REQ-1:0]             o_req_ready,
    input  logic [NUM_REQ*TEA_BLOCK_W-1:0] i_req_data,
    input  logic [NUM_REQ*TEA_KEY_W-1:0]   i_req_key,
    input  logic [NUM_REQ-1:0]             i_req_decrypt,
    output logic [NUM_REQ-1:0]             o_rsp_valid,
    input  logic [NUM_REQ-1:0]             i_rsp_ready,
    output logic [TEA_BLOCK_W-1:0]         o_rsp_data,
    output logic                           o_rsp_err,
    output logic                           o_axis_valid_m,
    input  logic                           i_axis_ready_m,
    output logic [TEA_BLOCK_W-1:0]         o_axis_data_m,
    output logic [TEA_KEY_W-1:0]           o_key_m,
    output logic                           o_decrypt_m,
    input  logic                           i_axis_valid_s,
    output logic                           o_axis_ready_s,
    input  logic [TEA_BLOCK_W-1:0]         i_axis_data_s
);

    localparam int IDX_W = idx_width(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("tea_scheduler: NUM_REQ must be 2..8");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 256) begin : g_bad_timeout
        $error("tea_scheduler: TIMEOUT_CYCLES must fit the 8-bit watchdog");
    end

    sched_state_e           state_q, state_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]       id_q, id_d;
    logic [TEA_BLOCK_W-1:0] data_q, data_d;
    logic [TEA_KEY_W-1:0]   key_q, key_d;
    logic                   dec_q, dec_d;
    logic [TEA_BLOCK_W-1:0] result_q, result_d;
    logic                   err_set, err_clr;
    logic                   timeout;

    logic [NUM_REQ-1:0]     pick_gnt;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;

    tea_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .valid_i (i_req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_gnt),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

`ifdef TEA_SCHED_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wd_cnt_q;
    logic       err_q;
    logic       drain_q;

    assign timeout = (state_q == ST_WAIT) && !i_axis_valid_s && (wd_cnt_q == TO_LAST);

    // Counter is zero on WAIT entry because it is held clear in every other state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
            drain_q  <= 1'b0;
        end else begin
            wd_cnt_q <= (state_q == ST_WAIT) ? wd_cnt_q + 8'd1 : 8'd0;
            drain_q  <= 1'b1;
            if (err_set) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign o_rsp_err      = err_q;
    assign o_axis_ready_s = (state_q == ST_WAIT) || ((state_q == ST_IDLE) && drain_q);
`else
    assign timeout        = 1'b0;
    assign o_rsp_err      = 1'b0;
    assign o_axis_ready_s = (state_q == ST_WAIT);
`endif

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        data_d   = data_q;
        key_d    = key_q;
        dec_d    = dec_q;
        result_d = result_q;
        err_set  = 1'b0;
        err_clr  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    id_d    = pick_idx;
                    data_d  = i_req_data[pick_idx*TEA_BLOCK_W +: TEA_BLOCK_W];
                    key_d   = i_req_key[pick_idx*TEA_KEY_W +: TEA_KEY_W];
                    dec_d   = i_req_decrypt[pick_idx];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (i_axis_ready_m) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_axis_valid_s) begin
                    result_d = i_axis_data_s;
                    err_clr  = 1'b1;
                    state_d  = ST_RETURN;
                end else if (timeout) begin
                    result_d = '0;
                    err_set  = 1'b1;
                    state_d  = ST_RETURN;
                end
            end
            ST_RETURN: begin
                if (i_rsp_ready[id_q]) begin
                    rr_ptr_d = (id_q == IDX_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Payload registers are reset too so the core-facing bus reads zero after reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            data_q   <= '0;
            key_q    <= '0;
            dec_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            data_q   <= data_d;
            key_q    <= key_d;
            dec_q    <= dec_d;
            result_q <= result_d;
        end
    end

    assign o_req_ready    = (state_q == ST_IDLE) ? pick_gnt : '0;
    assign o_axis_valid_m = (state_q == ST_ISSUE);
    assign o_axis_data_m  = data_q;
    assign o_key_m        = key_q;
    assign o_decrypt_m    = dec_q;
    assign o_rsp_valid    = (state_q == ST_RETURN) ? (NUM_REQ'(1) << id_q) : '0;
    assign o_rsp_data     = result_q;

endmodule

// File: tb/tb_tea_scheduler.sv
// Scoreboard bench for tea_scheduler with a behavioural fixed-latency core model.
module tb_tea_scheduler;

    localparam int N   = 4;
    localparam int LAT = 34;
    localparam int TO  = 64;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       req_valid, req_ready, req_dec;
    logic [N*64-1:0]    req_data;
    logic [N*128-1:0]   req_key;
    logic [N-1:0]       rsp_valid, rsp_ready;
    logic [63:0]        rsp_data;
    logic               rsp_err;
    logic               axm_valid, axm_ready, axm_dec;
    logic [63:0]        axm_data;
    logic [127:0]       axm_key;
    logic               axs_valid, axs_ready;
    logic [63:0]        axs_data;

    tea_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_data     (req_data),
        .i_req_key      (req_key),
        .i_req_decrypt  (req_dec),
        .o_rsp_valid    (rsp_valid),
        .i_rsp_ready    (rsp_ready),
        .o_rsp_data     (rsp_data),
        .o_rsp_err      (rsp_err),
        .o_axis_valid_m (axm_valid),
        .i_axis_ready_m (axm_ready),
        .o_axis_data_m  (axm_data),
        .o_key_m        (axm_key),
        .o_decrypt_m    (axm_dec),
        .i_axis_valid_s (axs_valid),
        .o_axis_ready_s (axs_ready),
        .i_axis_data_s  (axs_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int          id;
        logic [63:0] data;
        logic        err;
    } rsp_exp_t;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [192:0]  exp_in[$];
    rsp_exp_t      exp_rsp[$];
    int            grant_log[$];
    int            rsp_cnt = 0;
    int            core_acc = 0;
    int            cyc = 0;
    int            acc_cyc = 0;
    logic          core_hold = 1'b0;
    logic          core_mute = 1'b0;
    logic          core_busy = 1'b0;

    task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] core_f(input logic [63:0] d, input logic [127:0] k, input logic dc);
        return {d[31:0], d[63:32]} ^ k[63:0] ^ k[127:64] ^ {64{dc}};
    endfunction

    function automatic logic [N-1:0] exp_pick(input logic [N-1:0] v, input int p);
        for (int i = 0; i < N; i++) begin
            if (v[(p + i) % N]) return N'(1) << ((p + i) % N);
        end
        return '0;
    endfunction

    // Monitor + core model: checks at negedge, drives core-side inputs just after posedge.
    initial begin
        logic          m_idle;
        int            m_ptr;
        logic          acc_prev, res_prev, rsp_prev;
        int            core_cnt;
        logic          core_out_v;
        logic [63:0]   core_res;
        logic [N-1:0]  eg;
        rsp_exp_t      e;
        m_idle = 1'b1; m_ptr = 0; acc_prev = 1'b0; res_prev = 1'b0; rsp_prev = 1'b0;
        core_cnt = 0; core_out_v = 1'b0; core_res = '0;
        axm_ready = 1'b0; axs_valid = 1'b0; axs_data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                exp_in.delete(); exp_rsp.delete();
                m_idle = 1'b1; m_ptr = 0; acc_prev = 1'b0; res_prev = 1'b0; rsp_prev = 1'b0;
                core_busy = 1'b0; core_out_v = 1'b0; core_cnt = 0;
            end else begin
                if (acc_prev) check_eq("issue_lat", axm_valid, 1'b1);
                if (res_prev) check_eq("rsp_lat", |rsp_valid, 1'b1);
                acc_prev = 1'b0;
                res_prev = 1'b0;
                if (m_idle) begin
                    eg = exp_pick(req_valid, m_ptr);
                    if (|req_valid) check_eq("grant", req_ready, eg);
                    if (|(req_valid & req_ready)) begin
                        for (int k = 0; k < N; k++) begin
                            if (eg[k]) begin
                                exp_in.push_back({req_data[k*64 +: 64], req_key[k*128 +: 128], req_dec[k]});
                                e.id   = k;
                                e.data = core_mute ? 64'd0
                                       : core_f(req_data[k*64 +: 64], req_key[k*128 +: 128], req_dec[k]);
                                e.err  = core_mute;
                                exp_rsp.push_back(e);
                                grant_log.push_back(k);
                            end
                        end
                        m_idle   = 1'b0;
                        acc_prev = 1'b1;
                    end
                end else if (|req_valid) begin
                    check_eq("no_grant", req_ready, '0);
                end
                if (axm_valid) begin
                    if (exp_in.size() == 0) begin
                        check_eq("axm_spurious", axm_valid, 1'b0);
                    end else begin
                        check_eq("axm_payload", {axm_data, axm_key, axm_dec}, exp_in[0]);
                        if (axm_ready) begin
                            void'(exp_in.pop_front());
                            core_acc++;
                            acc_cyc = cyc;
                            if (!core_mute) begin
                                core_busy = 1'b1;
                                core_cnt  = LAT;
                                core_res  = core_f(axm_data, axm_key, axm_dec);
                            end
                        end
                    end
                end
                if (axs_valid && axs_ready) begin
                    core_out_v = 1'b0;
                    core_busy  = 1'b0;
                    res_prev   = 1'b1;
                end
                if (|rsp_valid) begin
                    if (exp_rsp.size() == 0) begin
                        check_eq("rsp_spurious", rsp_valid, '0);
                    end else begin
                        e = exp_rsp[0];
                        check_eq("rsp_valid", rsp_valid, N'(1) << e.id);
                        check_eq("rsp_data", rsp_data, e.data);
                        check_eq("rsp_err", rsp_err, e.err);
                        if (e.err && !rsp_prev) check_eq("timeout_lat", cyc - acc_cyc, TO + 1);
                        if (|(rsp_valid & rsp_ready)) begin
                            void'(exp_rsp.pop_front());
                            m_idle = 1'b1;
                            m_ptr  = (e.id + 1) % N;
                            rsp_cnt++;
                        end
                    end
                end
                rsp_prev = |rsp_valid;
            end
            @(posedge clk);
            #1;
            if (core_busy && !core_out_v) begin
                if (core_cnt == 0) core_out_v = 1'b1;
                else core_cnt--;
            end
            axs_valid = core_out_v;
            axs_data  = core_res;
            axm_ready = !core_busy && !core_hold;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [63:0] d, input logic [127:0] key, input logic dc);
        req_data[k*64 +: 64]   = d;
        req_key[k*128 +: 128]  = key;
        req_dec[k]             = dc;
    endtask

    task automatic send(input int k, input logic [63:0] d, input logic [127:0] key, input logic dc);
        int n0;
        n0 = grant_log.size();
        set_req(k, d, key, dc);
        req_valid[k] = 1'b1;
        for (int t = 0; t < 300 && grant_log.size() == n0; t++) tick();
        check_eq("accept_seen", grant_log.size() > n0, 1'b1);
        req_valid[k] = 1'b0;
    endtask

    task automatic wait_rsp(input int n);
        for (int t = 0; t < 500 && rsp_cnt < n; t++) tick();
        check_eq("rsp_seen", rsp_cnt >= n, 1'b1);
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_req_ready", req_ready, '0);
        check_eq("rst_rsp_valid", rsp_valid, '0);
        check_eq("rst_axm_valid", axm_valid, 1'b0);
        check_eq("rst_axs_ready", axs_ready, 1'b0);
        check_eq("rst_rsp_data", rsp_data, '0);
        check_eq("rst_axm_data", axm_data, '0);
        check_eq("rst_key", axm_key, '0);
        check_eq("rst_decrypt", axm_dec, 1'b0);
        check_eq("rst_rsp_err", rsp_err, 1'b0);
    endtask

    initial begin
        int n0;
        int r0;
        int a0;
        rst = 1'b1;
        req_valid = '0; req_data = '0; req_key = '0; req_dec = '0;
        rsp_ready = '1;
        tick(); tick();
        check_reset_outputs();
        rst = 1'b0;

        // Single encrypt from requester 2
        send(2, 64'h0123456789ABCDEF, 128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b0);
        wait_rsp(1);

        // All requesters valid straight out of reset
        rst = 1'b1;
        tick(); tick();
        n0 = grant_log.size();
        r0 = rsp_cnt;
        for (int k = 0; k < N; k++) begin
            set_req(k, 64'hA5A5_0000_0000_0000 + 64'(k * 17), {4{32'(k + 1) * 32'h1357_9BDF}}, k[0]);
        end
        req_valid = '1;
        rst = 1'b0;
        for (int t = 0; t < 600 && grant_log.size() < n0 + 5; t++) tick();
        req_valid = '0;
        check_eq("rr_count", grant_log.size() - n0, 5);
        for (int i = 0; i < 5 && n0 + i < grant_log.size(); i++) begin
            check_eq("rr_order", grant_log[n0 + i], i % N);
        end
        wait_rsp(r0 + 5);

        // Core back-pressure on the input side
        core_hold = 1'b1;
        a0 = core_acc;
        send(1, 64'hDEADBEEF_CAFEF00D, 128'hFEDCBA98_76543210_0F1E2D3C_4B5A6978, 1'b1);
        for (int t = 0; t < 5; t++) begin
            check_eq("hold_valid", axm_valid, 1'b1);
            tick();
        end
        core_hold = 1'b0;
        wait_rsp(rsp_cnt + 1);
        check_eq("single_xfer", core_acc - a0, 1);

        // Requester 1 stalls its response while requester 3 waits
        rsp_ready[1] = 1'b0;
        r0 = rsp_cnt;
        send(1, 64'h1111_2222_3333_4444, 128'h5555_6666_7777_8888_9999_AAAA_BBBB_CCCC, 1'b0);
        set_req(3, 64'h0BAD_F00D_1234_5678, 128'h1, 1'b1);
        req_valid[3] = 1'b1;
        for (int t = 0; t < 200 && !rsp_valid[1]; t++) tick();
        n0 = grant_log.size();
        for (int t = 0; t < 10; t++) begin
            check_eq("stall_hold", rsp_valid, 4'b0010);
            tick();
        end
        check_eq("no_new_grant", grant_log.size(), n0);
        rsp_ready[1] = 1'b1;
        for (int t = 0; t < 50 && grant_log.size() == n0; t++) tick();
        req_valid[3] = 1'b0;
        check_eq("next_grant_id", grant_log[grant_log.size() - 1], 3);
        wait_rsp(r0 + 2);

`ifdef TEA_SCHED_TIMEOUT_EN
        // Core never answers: watchdog returns an error response
        core_mute = 1'b1;
        r0 = rsp_cnt;
        send(3, 64'h7777_7777_7777_7777, 128'h42, 1'b0);
        wait_rsp(r0 + 1);
        core_mute = 1'b0;
`endif

        // Leave rr_ptr non-zero, then reset during WAIT
        send(0, 64'h0000_0000_0000_0001, 128'h2, 1'b0);
        wait_rsp(rsp_cnt + 1);
        send(2, 64'h2222_2222_2222_2222, 128'h3, 1'b1);
        for (int t = 0; t < 50 && !core_busy; t++) tick();
        tick(); tick(); tick();
        check_eq("in_wait", axs_ready && !axm_valid, 1'b1);
        rst = 1'b1;
        tick();
        check_reset_outputs();
        rst = 1'b0;
        r0 = rsp_cnt;
        repeat (60) tick();
        check_eq("no_rsp_after_rst", rsp_cnt, r0);
        n0 = grant_log.size();
        req_valid = '1;
        for (int t = 0; t < 50 && grant_log.size() == n0; t++) tick();
        req_valid = '0;
        check_eq("grant_after_rst", grant_log.size() > n0 ? grant_log[n0] : -1, 0);
        wait_rsp(r0 + 1);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0d expected %0d", 0, 1);
        $fatal(1, "bench did not finish");
    end

endmodule
